axis_width_conv_down_pkt: RTL and testbench

//   Packet-aware wide-to-narrow AXI-stream width converter: splits N-bit words into K=N/M
//   M-bit beats through a DEPTH-entry wide buffer. Carries tfirst/tlast; the last word may be

---
 rtl/axis_width_conv_down_pkt_if.sv | 33 +++
 rtl/axis_width_conv_down_pkt.sv | 123 ++++++++++++
 tb/tb_axis_width_conv_down_pkt.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_width_conv_down_pkt_if.sv
// rtl/axis_width_conv_down_pkt_if.sv - wide input / narrow output stream bundle for the down converter
// slave is the converter's view; master is the view of the source/sink around it.
interface axis_width_conv_down_pkt_if #(
  parameter int N   = 24,
  parameter int M   = 8,
  parameter int W_L = 2
);
  logic           s_axis_tnext;
  logic [N-1:0]   s_axis_tdata;
  logic           s_axis_tfirst;
  logic           s_axis_tlast;
  logic [W_L-1:0] s_axis_tlanes;
  logic           s_axis_tvalid;
  logic           m_axis_tnext;
  logic [M-1:0]   m_axis_tdata;
  logic           m_axis_tfirst;
  logic           m_axis_tlast;
  logic           m_axis_tvalid;

  modport slave (
    output s_axis_tnext,
    input  s_axis_tdata, s_axis_tfirst, s_axis_tlast, s_axis_tlanes, s_axis_tvalid,
    input  m_axis_tnext,
    output m_axis_tdata, m_axis_tfirst, m_axis_tlast, m_axis_tvalid
  );

  modport master (
    input  s_axis_tnext,
    output s_axis_tdata, s_axis_tfirst, s_axis_tlast, s_axis_tlanes, s_axis_tvalid,
    output m_axis_tnext,
    input  m_axis_tdata, m_axis_tfirst, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/axis_width_conv_down_pkt.sv
// rtl/axis_width_conv_down_pkt.sv - packet-aware N-to-M bit stream width down converter
// Wide words sit in a DEPTH-entry buffer; a lane counter walks the head entry one beat per transfer.
module axis_width_conv_down_pkt #(
  parameter int N         = 24,
  parameter int M         = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int K        = N / M,
  localparam int W_L      = (K > 1) ? $clog2(K) : 1,
  localparam int W_D      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  axis_width_conv_down_pkt_if.slave    bus,
  output logic [W_D:0]                 level,
  output logic [15:0]                  beat_count
);

  if (N % M != 0) begin : g_bad_width
    $error("axis_width_conv_down_pkt: N must be a multiple of M");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_width_conv_down_pkt: DEPTH must be a power of two >= 2");
  end

  logic [N-1:0]   data_mem  [DEPTH];
  logic           first_mem [DEPTH];
  logic           last_mem  [DEPTH];
  logic [W_L-1:0] ll_mem    [DEPTH];

  logic [W_D:0]   wr_ptr_q, wr_ptr_d;
  logic [W_D:0]   rd_ptr_q, rd_ptr_d;
  logic [W_L-1:0] lane_q, lane_d;
  logic [15:0]    beat_count_q, beat_count_d;

  logic [W_D:0]   level_w;
  logic           full;
  logic           push;
  logic           valid;
  logic           xfer;
  logic           last_beat;
  logic [W_D-1:0] wr_idx;
  logic [W_D-1:0] rd_idx;
  logic [W_L-1:0] in_ll;
  logic [W_L-1:0] head_ll;
  logic [W_L-1:0] lane_idx;
  logic [N-1:0]   head_word;
  logic [M-1:0]   beat;

  // Extra wrap bit on both pointers lets the difference cover 0..DEPTH.
  assign level_w   = wr_ptr_q - rd_ptr_q;
  assign full      = (level_w == (W_D + 1)'(DEPTH));
  assign wr_idx    = wr_ptr_q[W_D-1:0];
  assign rd_idx    = rd_ptr_q[W_D-1:0];
  assign push      = rst && bus.s_axis_tvalid && !full;
  assign valid     = rst && (level_w != '0);
  assign xfer      = valid && bus.m_axis_tnext;
  assign head_ll   = ll_mem[rd_idx];
  assign head_word = data_mem[rd_idx];
  assign last_beat = (lane_q == head_ll);
  assign lane_idx  = MSB_FIRST ? (W_L'(K - 1) - lane_q) : lane_q;
  assign beat      = M'(head_word >> (int'(lane_idx) * M));

  // Stored as index of the last valid lane; oversize tlanes clamps to a full word.
  always_comb begin
    in_ll = W_L'(K - 1);
    if (bus.s_axis_tlast && (bus.s_axis_tlanes < W_L'(K - 1))) begin
      in_ll = bus.s_axis_tlanes;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lane_d       = lane_q;
    beat_count_d = beat_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (xfer) begin
      beat_count_d = beat_count_q + 16'd1;
      if (last_beat) begin
        lane_d   = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lane_q       <= '0;
      beat_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lane_q       <= lane_d;
      beat_count_q <= beat_count_d;
    end
  end

  // Buffer contents are never reset; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_idx]  <= bus.s_axis_tdata;
      first_mem[wr_idx] <= bus.s_axis_tfirst;
      last_mem[wr_idx]  <= bus.s_axis_tlast;
      ll_mem[wr_idx]    <= in_ll;
    end
  end

  assign bus.s_axis_tnext  = push;
  assign bus.m_axis_tvalid = valid;
  assign bus.m_axis_tdata  = valid ? beat : '0;
  assign bus.m_axis_tfirst = valid && (lane_q == '0) && first_mem[rd_idx];
  assign bus.m_axis_tlast  = valid && last_beat && last_mem[rd_idx];
  assign level             = level_w;
  assign beat_count        = beat_count_q;

endmodule

// File: tb/tb_axis_width_conv_down_pkt.sv
// tb/tb_axis_width_conv_down_pkt.sv - directed self-checking bench for axis_width_conv_down_pkt
// dut0 emits MSB lane first, dut1 LSB lane first; beats on dut0 are logged by a negedge monitor.
module tb_axis_width_conv_down_pkt;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  level0, level1;
  logic [15:0] beat_count0, beat_count1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int last_acc  = 0;

  logic [9:0] mon_q[$];
  int         mon_cyc[$];

  axis_width_conv_down_pkt_if #(.N(24), .M(8), .W_L(2)) bus0 ();
  axis_width_conv_down_pkt_if #(.N(24), .M(8), .W_L(2)) bus1 ();

  axis_width_conv_down_pkt #(.N(24), .M(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .level(level0), .beat_count(beat_count0)
  );
  axis_width_conv_down_pkt #(.N(24), .M(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .level(level1), .beat_count(beat_count1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus0.m_axis_tvalid && bus0.m_axis_tnext) begin
      mon_q.push_back({bus0.m_axis_tfirst, bus0.m_axis_tlast, bus0.m_axis_tdata});
      mon_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at posedge+1; holds the word until it is accepted, returns at posedge+1.
  task automatic push_word(input logic [23:0] d, input logic f, input logic l, input logic [1:0] ln);
    logic ok;
    ok = 1'b0;
    bus0.s_axis_tdata  = d;
    bus0.s_axis_tfirst = f;
    bus0.s_axis_tlast  = l;
    bus0.s_axis_tlanes = ln;
    bus0.s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus0.s_axis_tnext;
      if (ok) last_acc = cyc;
      @(posedge clk);
      #1;
    end
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(posedge clk);
      #1;
      idle = (level0 == 3'd0) && !bus0.m_axis_tvalid;
    end
    chk("drain", 32'(idle), 32'd1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int errs;
    int c0;
    logic [7:0] exp_b;

    bus0.s_axis_tdata = '0; bus0.s_axis_tfirst = 1'b0; bus0.s_axis_tlast = 1'b0;
    bus0.s_axis_tlanes = '0; bus0.s_axis_tvalid = 1'b1; bus0.m_axis_tnext = 1'b1;
    bus1.s_axis_tdata = '0; bus1.s_axis_tfirst = 1'b0; bus1.s_axis_tlast = 1'b0;
    bus1.s_axis_tlanes = '0; bus1.s_axis_tvalid = 1'b0; bus1.m_axis_tnext = 1'b1;

    // reset state, input offered while in reset
    @(posedge clk); #1;
    chk("rst_s_tnext", 32'(bus0.s_axis_tnext), 32'd0);
    chk("rst_m_tvalid", 32'(bus0.m_axis_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(bus0.m_axis_tdata), 32'd0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_beat_count", 32'(beat_count0), 32'd0);
    bus0.s_axis_tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1: single full word packet
    mon_q.delete(); mon_cyc.delete();
    push_word(24'hAABBCC, 1'b1, 1'b1, 2'd2);
    bus0.s_axis_tvalid = 1'b0;
    wait_idle();
    chk("t1_n", 32'(mon_q.size()), 32'd3);
    chk("t1_b0", 32'(mon_q[0]), {22'd0, 2'b10, 8'hAA});
    chk("t1_b1", 32'(mon_q[1]), {22'd0, 2'b00, 8'hBB});
    chk("t1_b2", 32'(mon_q[2]), {22'd0, 2'b01, 8'hCC});
    chk("t1_lat0", 32'(mon_cyc[0]), 32'(last_acc + 1));
    chk("t1_lat2", 32'(mon_cyc[2]), 32'(last_acc + 3));
    chk("t1_beat_count", 32'(beat_count0), 32'd3);

    // 2: partial last word with one lane
    mon_q.delete(); mon_cyc.delete();
    push_word(24'h112233, 1'b1, 1'b0, 2'd0);
    push_word(24'h445566, 1'b0, 1'b1, 2'd0);
    bus0.s_axis_tvalid = 1'b0;
    wait_idle();
    chk("t2_n", 32'(mon_q.size()), 32'd4);
    chk("t2_b0", 32'(mon_q[0]), {22'd0, 2'b10, 8'h11});
    chk("t2_b1", 32'(mon_q[1]), {22'd0, 2'b00, 8'h22});
    chk("t2_b2", 32'(mon_q[2]), {22'd0, 2'b00, 8'h33});
    chk("t2_b3", 32'(mon_q[3]), {22'd0, 2'b01, 8'h44});
    chk("t2_level", 32'(level0), 32'd0);

    // tlanes boundaries: 3 clamps to a full word, 1 gives two lanes
    mon_q.delete(); mon_cyc.delete();
    push_word(24'h010203, 1'b1, 1'b1, 2'd3);
    push_word(24'h040506, 1'b1, 1'b1, 2'd1);
    bus0.s_axis_tvalid = 1'b0;
    wait_idle();
    chk("clamp_n", 32'(mon_q.size()), 32'd5);
    chk("clamp_b0", 32'(mon_q[0]), {22'd0, 2'b10, 8'h01});
    chk("clamp_b2", 32'(mon_q[2]), {22'd0, 2'b01, 8'h03});
    chk("part_b3", 32'(mon_q[3]), {22'd0, 2'b10, 8'h04});
    chk("part_b4", 32'(mon_q[4]), {22'd0, 2'b01, 8'h05});

    // 3: stalled sink, buffer fills, fifth word waits for the first pop
    mon_q.delete(); mon_cyc.delete();
    bus0.m_axis_tnext = 1'b0;
    push_word(24'h102030, 1'b1, 1'b0, 2'd0);
    push_word(24'h405060, 1'b0, 1'b0, 2'd0);
    push_word(24'h708090, 1'b0, 1'b0, 2'd0);
    push_word(24'hA0B0C0, 1'b0, 1'b0, 2'd0);
    bus0.s_axis_tdata = 24'hD0E0F0; bus0.s_axis_tfirst = 1'b0;
    bus0.s_axis_tlast = 1'b1; bus0.s_axis_tlanes = 2'd2;
    @(negedge clk);
    chk("t3_full_tnext", 32'(bus0.s_axis_tnext), 32'd0);
    chk("t3_full_level", 32'(level0), 32'd4);
    chk("t3_tvalid_stalled", 32'(bus0.m_axis_tvalid), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_still_full", 32'(bus0.s_axis_tnext), 32'd0);
    bus0.m_axis_tnext = 1'b1;
    c0 = cyc;
    push_word(24'hD0E0F0, 1'b0, 1'b1, 2'd2);
    bus0.s_axis_tvalid = 1'b0;
    chk("t3_acc5_cyc", 32'(last_acc), 32'(c0 + 3));
    wait_idle();
    chk("t3_n", 32'(mon_q.size()), 32'd15);
    errs = 0;
    for (int j = 0; j < 15; j++) begin
      exp_b = 8'((j + 1) * 16);
      if (mon_q[j] !== {(j == 0), (j == 14), exp_b}) errs++;
    end
    chk("t3_order_errs", 32'(errs), 32'd0);

    // 4: 100 words streamed, output must never bubble
    do_reset();
    mon_q.delete(); mon_cyc.delete();
    for (int i = 0; i < 100; i++) begin
      push_word({8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2)}, (i == 0), (i == 99), 2'd2);
    end
    bus0.s_axis_tvalid = 1'b0;
    wait_idle();
    chk("t4_n", 32'(mon_q.size()), 32'd300);
    errs = 0;
    for (int j = 0; j < 300; j++) begin
      if (mon_q[j] !== {(j == 0), (j == 299), 8'(j)}) errs++;
    end
    chk("t4_data_errs", 32'(errs), 32'd0);
    chk("t4_no_bubble", 32'(mon_cyc[299] - mon_cyc[0]), 32'd299);
    chk("t4_beat_count", 32'(beat_count0), 32'd300);

    // 5: reset asserted while the second lane is on the output
    bus0.m_axis_tnext = 1'b0;
    push_word(24'hA1A2A3, 1'b1, 1'b0, 2'd0);
    push_word(24'hB1B2B3, 1'b0, 1'b0, 2'd0);
    push_word(24'hC1C2C3, 1'b0, 1'b1, 2'd2);
    bus0.s_axis_tvalid = 1'b0;
    chk("t5_level3", 32'(level0), 32'd3);
    bus0.m_axis_tnext = 1'b1;
    @(negedge clk);
    chk("t5_lane0", 32'(bus0.m_axis_tdata), 32'hA1);
    @(negedge clk);
    chk("t5_lane1", 32'(bus0.m_axis_tdata), 32'hA2);
    bus0.s_axis_tvalid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_tvalid", 32'(bus0.m_axis_tvalid), 32'd0);
    chk("t5_rst_tdata", 32'(bus0.m_axis_tdata), 32'd0);
    chk("t5_rst_flags", 32'({bus0.m_axis_tfirst, bus0.m_axis_tlast}), 32'd0);
    chk("t5_rst_s_tnext", 32'(bus0.s_axis_tnext), 32'd0);
    chk("t5_rst_level", 32'(level0), 32'd0);
    bus0.s_axis_tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_post_level", 32'(level0), 32'd0);
    chk("t5_post_tvalid", 32'(bus0.m_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    mon_q.delete(); mon_cyc.delete();
    push_word(24'hDDEEFF, 1'b1, 1'b1, 2'd2);
    bus0.s_axis_tvalid = 1'b0;
    wait_idle();
    chk("t5_n", 32'(mon_q.size()), 32'd3);
    chk("t5_b0", 32'(mon_q[0]), {22'd0, 2'b10, 8'hDD});
    chk("t5_b1", 32'(mon_q[1]), {22'd0, 2'b00, 8'hEE});
    chk("t5_b2", 32'(mon_q[2]), {22'd0, 2'b01, 8'hFF});
    chk("t5_beat_count", 32'(beat_count0), 32'd3);

    // 6: LSB lane first on dut1
    bus1.s_axis_tdata = 24'hAABBCC; bus1.s_axis_tfirst = 1'b1;
    bus1.s_axis_tlast = 1'b1; bus1.s_axis_tlanes = 2'd2; bus1.s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("t6_accept", 32'(bus1.s_axis_tnext), 32'd1);
    @(posedge clk); #1 bus1.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_b0", 32'({bus1.m_axis_tvalid, bus1.m_axis_tfirst, bus1.m_axis_tlast, bus1.m_axis_tdata}), {21'd0, 3'b110, 8'hCC});
    @(negedge clk);
    chk("t6_b1", 32'({bus1.m_axis_tvalid, bus1.m_axis_tfirst, bus1.m_axis_tlast, bus1.m_axis_tdata}), {21'd0, 3'b100, 8'hBB});
    @(negedge clk);
    chk("t6_b2", 32'({bus1.m_axis_tvalid, bus1.m_axis_tfirst, bus1.m_axis_tlast, bus1.m_axis_tdata}), {21'd0, 3'b101, 8'hAA});
    @(negedge clk);
    chk("t6_idle", 32'(bus1.m_axis_tvalid), 32'd0);
    chk("t6_beat_count", 32'(beat_count1), 32'd3);
    chk("t6_level", 32'(level1), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
